// File: rtl/aes128_package.sv
// Shared types and helpers for the masked AES datapath: the quadratic-term count
// used by the HPC3 multipliers and the xorshift64 randomness generator.
package aes128_package;

  localparam logic [63:0] XS_ZERO_SEED = 64'h9E3779B97F4A7C15;

  typedef enum logic [1:0] {IDLE, SEED_HI, WARMUP, RUN} rng_state_e;

  function automatic int num_quad(input int numShares);
    return numShares * (numShares - 1) / 2;
  endfunction

  // One xorshift64 step: shifts 13, 7, 17 applied in that order.
  function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

endpackage

// File: rtl/masked_rand_gen_xorshift64_core.sv
// Combinational next-state logic of the xorshift64 generator; no state is held here.
module xorshift64_core
  import aes128_package::*;
(
  input  logic [63:0] x_i,
  output logic [63:0] x_o
);

  assign x_o = xorshift64_step(x_i);

endmodule

// File: rtl/masked_rand_gen.sv
// Fresh-randomness source for the HPC3 multiplier layer: a seeded xorshift64 generator
// whose state is sliced into disjoint in_r / in_p words for each multiplier.
module masked_rand_gen
  import aes128_package::*;
#(
  parameter int NUM_SHARES = 3,
  parameter int BIT_WIDTH  = 1,
  parameter int NUM_MULS   = 2,
  parameter int WARMUP     = 4,
  localparam int NUM_QUADRATIC = num_quad(NUM_SHARES)
) (
  input  logic                                                in_clock,
  input  logic                                                in_reset,
  input  logic [31:0]                                         in_seed,
  input  logic                                                in_seed_valid,
  output logic                                                out_seed_ready,
  output logic [NUM_MULS-1:0][NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] out_r,
  output logic [NUM_MULS-1:0][NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] out_p,
  output logic                                                out_valid
);

  localparam int OUT_BITS = 2 * NUM_MULS * NUM_QUADRATIC * BIT_WIDTH;
  localparam int R_BITS   = OUT_BITS / 2;
  localparam logic [7:0] WARM_LAST = 8'((WARMUP > 0) ? WARMUP - 1 : 0);

  if (OUT_BITS > 64) begin : g_out_bits_check
    $error("masked_rand_gen: OUT_BITS exceeds the 64-bit generator state");
  end
  if (WARMUP < 0 || WARMUP > 255) begin : g_warmup_check
    $error("masked_rand_gen: WARMUP must lie in 0..255");
  end

  rng_state_e        state_q, state_d;
  logic [63:0]       x_q, x_d, xStep;
  logic [7:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [R_BITS-1:0] r_q, r_d, p_q, p_d;
  logic              seedFire;

  xorshift64_core u_core (
    .x_i (x_q),
    .x_o (xStep)
  );

  assign out_seed_ready = (state_q != aes128_package::WARMUP);
  assign seedFire       = in_seed_valid && out_seed_ready;

  // Outputs are registered from the RUN-state value of x, so they lag the generator
  // by one cycle and a reseed still lets the current RUN word out.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    r_d     = '0;
    p_d     = '0;
    case (state_q)
      IDLE: begin
        if (seedFire) begin
          x_d[31:0] = in_seed;
          state_d   = SEED_HI;
        end
      end
      SEED_HI: begin
        if (seedFire) begin
          if ({in_seed, x_q[31:0]} == 64'd0) x_d = XS_ZERO_SEED;
          else                               x_d = {in_seed, x_q[31:0]};
          cnt_d   = 8'd0;
          state_d = (WARMUP == 0) ? RUN : aes128_package::WARMUP;
        end
      end
      aes128_package::WARMUP: begin
        x_d   = xStep;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == WARM_LAST) state_d = RUN;
      end
      RUN: begin
        valid_d = 1'b1;
        r_d     = x_q[R_BITS-1:0];
        p_d     = x_q[OUT_BITS-1:R_BITS];
        if (seedFire) begin
          x_d[31:0] = in_seed;
          state_d   = SEED_HI;
        end else begin
          x_d = xStep;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      r_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      r_q     <= r_d;
      p_q     <= p_d;
    end
  end

  assign out_r     = r_q;
  assign out_p     = p_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_masked_rand_gen.sv
// Directed bench for masked_rand_gen with WARMUP=1: seeding, warmup latency, long RUN
// sequence against an xorshift64 model, reseed, zero seed and reset recovery.
module tb_masked_rand_gen;

  localparam int NUM_SHARES = 3;
  localparam int BIT_WIDTH  = 1;
  localparam int NUM_MULS   = 2;
  localparam int WARMUP     = 1;
  localparam int NQ         = NUM_SHARES * (NUM_SHARES - 1) / 2;
  localparam int RB         = NUM_MULS * NQ * BIT_WIDTH;

  logic                                     clock;
  logic                                     reset;
  logic [31:0]                              seed;
  logic                                     seedValid;
  logic                                     seedReady;
  logic [NUM_MULS-1:0][NQ-1:0][BIT_WIDTH-1:0] outR;
  logic [NUM_MULS-1:0][NQ-1:0][BIT_WIDTH-1:0] outP;
  logic                                     outValid;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] model;

  masked_rand_gen #(
    .NUM_SHARES (NUM_SHARES),
    .BIT_WIDTH  (BIT_WIDTH),
    .NUM_MULS   (NUM_MULS),
    .WARMUP     (WARMUP)
  ) dut (
    .in_clock       (clock),
    .in_reset       (reset),
    .in_seed        (seed),
    .in_seed_valid  (seedValid),
    .out_seed_ready (seedReady),
    .out_r          (outR),
    .out_p          (outP),
    .out_valid      (outValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] refStep(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkModel(input string tag, input logic [63:0] x);
    checkOutput({tag, "_valid"}, 64'(outValid), 64'd1);
    checkOutput({tag, "_r"}, 64'(outR), 64'(x[RB-1:0]));
    checkOutput({tag, "_p"}, 64'(outP), 64'(x[2*RB-1:RB]));
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_valid"}, 64'(outValid), 64'd0);
    checkOutput({tag, "_r"}, 64'(outR), 64'd0);
    checkOutput({tag, "_p"}, 64'(outP), 64'd0);
  endtask

  // Presents one word on the seed link for exactly one rising edge.
  task automatic applyStimulus(input logic [31:0] word);
    @(negedge clock);
    checkOutput("seed_ready", 64'(seedReady), 64'd1);
    seed      = word;
    seedValid = 1'b1;
    @(negedge clock);
    seedValid = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    seed      = '0;
    seedValid = 1'b0;
    #12;
    checkOutput("reset_ready", 64'(seedReady), 64'd1);
    checkQuiet("reset");
    @(negedge clock);
    reset = 1'b1;

    applyStimulus(32'h0000_0001);
    applyStimulus(32'h0000_0000);
    checkOutput("warmup_ready", 64'(seedReady), 64'd0);
    checkOutput("warmup_valid", 64'(outValid), 64'd0);
    @(negedge clock);
    checkOutput("latency_valid", 64'(outValid), 64'd0);
    @(negedge clock);
    checkOutput("first_r", 64'(outR), 64'h01);
    checkOutput("first_p", 64'(outP), 64'h01);
    model = 64'h0000_0000_4082_2041;
    checkModel("first", model);

    for (int i = 0; i < 1000; i++) begin
      model = refStep(model);
      @(negedge clock);
      checkModel("run", model);
    end

    seed      = 32'hCAFE_F00D;
    seedValid = 1'b1;
    @(negedge clock);
    seedValid = 1'b0;
    model = refStep(model);
    checkModel("reseed_tail", model);
    @(negedge clock);
    checkQuiet("reseed_drop");
    applyStimulus(32'h1234_5678);
    @(negedge clock);
    checkQuiet("reseed_warm");
    @(negedge clock);
    model = refStep(64'h1234_5678_CAFE_F00D);
    checkModel("reseed_first", model);
    for (int i = 0; i < 20; i++) begin
      model = refStep(model);
      @(negedge clock);
      checkModel("reseed_run", model);
    end

    seed      = 32'h0000_0000;
    seedValid = 1'b1;
    @(negedge clock);
    seedValid = 1'b0;
    applyStimulus(32'h0000_0000);
    @(negedge clock);
    @(negedge clock);
    model = refStep(64'h9E37_79B9_7F4A_7C15);
    checkModel("zero_seed_first", model);
    for (int i = 0; i < 20; i++) begin
      model = refStep(model);
      @(negedge clock);
      checkModel("zero_seed_run", model);
    end

    reset = 1'b0;
    #1;
    checkOutput("run_reset_ready", 64'(seedReady), 64'd1);
    checkQuiet("run_reset");
    @(negedge clock);
    reset = 1'b1;

    applyStimulus(32'h5555_AAAA);
    applyStimulus(32'h7777_3333);
    checkOutput("warm_before_reset_ready", 64'(seedReady), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("warm_reset_ready", 64'(seedReady), 64'd1);
    checkQuiet("warm_reset");
    @(negedge clock);
    reset = 1'b1;

    applyStimulus(32'hDEAD_BEEF);
    reset = 1'b0;
    #1;
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(32'h0BAD_F00D);
    applyStimulus(32'h00C0_FFEE);
    @(negedge clock);
    checkQuiet("partial_warm");
    @(negedge clock);
    model = refStep(64'h00C0_FFEE_0BAD_F00D);
    checkModel("partial_first", model);
    for (int i = 0; i < 10; i++) begin
      model = refStep(model);
      @(negedge clock);
      checkModel("partial_run", model);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
